// File: rtl/serial_addr_pkg.sv
// serial_addr_pkg
//   Shared definitions for the bit-serial adder and later multi-cycle
//   arithmetic blocks:
//   - state_t: 2-bit IDLE/RUN/DONE encodings for the sequencing FSM
//   - width_ok(): legality check for the operand width (1..64)
//   - cnt_width(): bit-counter width, max(1, clog2(width))
//   - half_add(): 1-bit half adder, returns {carry, sum}
package serial_addr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 64;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

endpackage

// File: rtl/serial_addr_if.sv
// serial_addr_if
//   Start/done handshake and operand/result bus of the bit-serial adder.
//   master: controller side, drives start/a/b/cin, observes the result.
//   slave : adder side, consumes the request, drives busy/done/sum/cout/overflow.
//   Signals:
//     start     request a new addition
//     a, b      operands (WIDTH bits), cin carry-in
//     busy      computation in progress
//     done      one-cycle pulse when sum/cout/overflow are updated
//     sum       result of the last completed addition
//     cout      unsigned carry-out, overflow signed overflow
interface serial_addr_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );

endinterface

// File: rtl/serial_addr_full_addr.sv
// serial_addr_full_addr
//   1-bit full adder built from two half adders and an OR of their carries.
//   Ports:
//     in1, in2  addend bits
//     cin       carry in
//     out       sum bit
//     cout      carry out
module serial_addr_full_addr
    import serial_addr_pkg::*;
(
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic out,
    output logic cout
);

    logic [1:0] ha0;
    logic [1:0] ha1;

    assign ha0  = half_add(in1, in2);
    assign ha1  = half_add(ha0[0], cin);
    assign out  = ha1[0];
    // At most one of the two half-adder carries can be set.
    assign cout = ha0[1] | ha1[1];

endmodule

// File: rtl/serial_addr.sv
// serial_addr
//   Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first,
//   using a single full adder and a carry flop. Start is accepted in IDLE or
//   DONE; RUN lasts WIDTH cycles; done pulses for one cycle afterwards.
//   Ports:
//     clk   system clock (rising edge)
//     rst   synchronous active-high reset
//     bus   serial_addr_if slave: start/a/b/cin in, busy/done/sum/cout/overflow out
module serial_addr
    import serial_addr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    serial_addr_if.slave bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  TERM = CW'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serial_addr: WIDTH must lie in 1..64");
    end

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    serial_addr_full_addr u_fa (
        .in1  (opa[0]),
        .in2  (opb[0]),
        .cin  (carry),
        .out  (fa_sum),
        .cout (fa_cout)
    );

    // The result shift register only needs the WIDTH-1 bits finished before
    // the last step; the final bit comes straight from the adder, so the full
    // word is formed combinationally and captured on the completing edge.
    if (WIDTH == 1) begin : g_res_w1
        assign res_next = fa_sum;
    end else begin : g_res_wn
        logic [WIDTH-2:0] res;

        assign res_next = {fa_sum, res};

        always_ff @(posedge clk) begin
            if (rst)
                res <= '0;
            else if (state == RUN)
                res <= res_next[WIDTH-1:1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        opa    <= bus.a;
                        opb    <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == TERM) begin
                        sum_q  <= res_next;
                        cout_q <= fa_cout;
                        // carry currently holds the carry into the MSB.
                        ovf_q  <= carry ^ fa_cout;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule
